// File: rtl/psram_pkg.sv
// Shared types and widths for the PSRAM fetch arbiter and anything that talks
// to the QPI controller.
package psram_pkg;

    localparam int PSRAM_AW = 24;
    localparam int PSRAM_DW = 16;
    localparam int SLOT_MAX = 255;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_ACCEPT = 2'd1,
        WAIT_DONE   = 2'd2
    } fetch_state_t;

    typedef enum logic {
        OWN_VIDEO = 1'b0,
        OWN_CPU   = 1'b1
    } fetch_owner_t;

endpackage

// File: rtl/psram_fetch_arbiter.sv
// Single-client front end of the PSRAM controller: video line prefetch has
// priority, and a waiting CPU access is forced in after every CPU_EVERY video words.
module psram_fetch_arbiter
    import psram_pkg::*;
#(
    parameter int LINE_WORDS = 320,
    parameter int CPU_EVERY  = 8,
    parameter int LB_AW      = $clog2(LINE_WORDS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_line_req,
    input  logic [PSRAM_AW-1:0] i_line_addr,
    output logic                o_line_busy,
    output logic                o_line_done,
    output logic                o_lb_we,
    output logic [LB_AW-1:0]    o_lb_waddr,
    output logic [PSRAM_DW-1:0] o_lb_wdata,
    input  logic                i_cpu_stb,
    input  logic                i_cpu_we,
    input  logic [PSRAM_AW-1:0] i_cpu_addr,
    input  logic [PSRAM_DW-1:0] i_cpu_din,
    output logic                o_cpu_ack,
    output logic [PSRAM_DW-1:0] o_cpu_dout,
    output logic                o_psram_stb,
    output logic                o_psram_we,
    output logic [PSRAM_AW-1:0] o_psram_addr,
    output logic [PSRAM_DW-1:0] o_psram_din,
    input  logic                i_psram_busy,
    input  logic                i_psram_done,
    input  logic [PSRAM_DW-1:0] i_psram_dout,
    output logic [1:0]          o_state
);

    localparam logic [7:0]       CPU_EVERY_W = 8'(CPU_EVERY);
    localparam logic [7:0]       SLOT_SAT    = 8'(SLOT_MAX);
    localparam logic [LB_AW-1:0] LAST_IDX    = LB_AW'(LINE_WORDS - 1);

    fetch_state_t        state_q, state_d;
    fetch_owner_t        owner_q, owner_d;
    logic                stb_q, stb_d;
    logic                we_q, we_d;
    logic [PSRAM_AW-1:0] addr_q, addr_d;
    logic [PSRAM_DW-1:0] din_q, din_d;
    logic                line_active_q, line_active_d;
    logic [PSRAM_AW-1:0] line_base_q, line_base_d;
    logic [LB_AW-1:0]    idx_q, idx_d;
    logic [7:0]          slot_q, slot_d;
    logic                lb_we_q, lb_we_d;
    logic [LB_AW-1:0]    lb_waddr_q, lb_waddr_d;
    logic [PSRAM_DW-1:0] lb_wdata_q, lb_wdata_d;
    logic                line_done_q, line_done_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic [PSRAM_DW-1:0] cpu_dout_q, cpu_dout_d;

    logic                ready;
    logic                line_start;
    logic                line_act;
    logic [PSRAM_AW-1:0] line_base;
    logic [7:0]          slot_eff;
    logic                cpu_grant;
    logic                vid_grant;
    logic                issue;
    logic [PSRAM_AW-1:0] vid_addr;
    logic                last_word;

    // A line request arriving this cycle already counts as an active line with
    // slot_cnt at zero, so it beats a CPU request that shows up in the same cycle.
    assign ready      = !i_psram_busy && i_psram_done;
    assign line_start = i_line_req && !line_active_q;
    assign line_act   = line_active_q || line_start;
    assign line_base  = line_start ? i_line_addr : line_base_q;
    assign slot_eff   = line_start ? 8'd0 : slot_q;
    // The CPU still holds its strobe during the ack cycle; never re-grant it then.
    assign cpu_grant  = i_cpu_stb && !cpu_ack_q && (!line_act || slot_eff >= CPU_EVERY_W);
    assign vid_grant  = !cpu_grant && line_act;
    assign issue      = (state_q == IDLE) && ready && (cpu_grant || vid_grant);
    assign vid_addr   = line_base + PSRAM_AW'(idx_q);
    assign last_word  = (idx_q == LAST_IDX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_VIDEO;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            din_q         <= '0;
            line_active_q <= 1'b0;
            line_base_q   <= '0;
            idx_q         <= '0;
            slot_q        <= '0;
            lb_we_q       <= 1'b0;
            lb_waddr_q    <= '0;
            lb_wdata_q    <= '0;
            line_done_q   <= 1'b0;
            cpu_ack_q     <= 1'b0;
            cpu_dout_q    <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            stb_q         <= stb_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            line_active_q <= line_active_d;
            line_base_q   <= line_base_d;
            idx_q         <= idx_d;
            slot_q        <= slot_d;
            lb_we_q       <= lb_we_d;
            lb_waddr_q    <= lb_waddr_d;
            lb_wdata_q    <= lb_wdata_d;
            line_done_q   <= line_done_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_dout_q    <= cpu_dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:        if (issue)        state_d = WAIT_ACCEPT;
            WAIT_ACCEPT: if (i_psram_busy) state_d = WAIT_DONE;
            WAIT_DONE:   if (i_psram_done) state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d       = owner_q;
        stb_d         = stb_q;
        we_d          = we_q;
        addr_d        = addr_q;
        din_d         = din_q;
        line_active_d = line_act;
        line_base_d   = line_base;
        idx_d         = idx_q;
        slot_d        = slot_eff;
        lb_we_d       = 1'b0;
        lb_waddr_d    = lb_waddr_q;
        lb_wdata_d    = lb_wdata_q;
        line_done_d   = 1'b0;
        cpu_ack_d     = 1'b0;
        cpu_dout_d    = cpu_dout_q;

        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    stb_d = 1'b1;
                    if (cpu_grant) begin
                        owner_d = OWN_CPU;
                        we_d    = i_cpu_we;
                        addr_d  = i_cpu_addr;
                        din_d   = i_cpu_din;
                        slot_d  = 8'd0;
                    end else begin
                        owner_d = OWN_VIDEO;
                        we_d    = 1'b0;
                        addr_d  = vid_addr;
                        din_d   = '0;
                    end
                end
            end
            WAIT_ACCEPT: begin
                if (i_psram_busy) stb_d = 1'b0;
            end
            WAIT_DONE: begin
                // addr/we/din stay untouched here: the controller samples them mid-transaction.
                if (i_psram_done) begin
                    if (owner_q == OWN_VIDEO) begin
                        lb_we_d    = 1'b1;
                        lb_waddr_d = idx_q;
                        lb_wdata_d = i_psram_dout;
                        if (slot_q != SLOT_SAT) slot_d = slot_q + 8'd1;
                        if (last_word) begin
                            line_done_d   = 1'b1;
                            line_active_d = 1'b0;
                            idx_d         = '0;
                        end else begin
                            idx_d = idx_q + LB_AW'(1);
                        end
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!we_q) cpu_dout_d = i_psram_dout;
                    end
                end
            end
            default: ;
        endcase
    end

    assign o_state      = state_q;
    assign o_psram_stb  = stb_q;
    assign o_psram_we   = we_q;
    assign o_psram_addr = addr_q;
    assign o_psram_din  = din_q;
    assign o_line_busy  = line_active_q;
    assign o_line_done  = line_done_q;
    assign o_lb_we      = lb_we_q;
    assign o_lb_waddr   = lb_waddr_q;
    assign o_lb_wdata   = lb_wdata_q;
    assign o_cpu_ack    = cpu_ack_q;
    assign o_cpu_dout   = cpu_dout_q;

endmodule
